// File: rtl/accum_stage.sv
// Multi-operand signed accumulator behind a valid/ready handshake; COUNT beats per batch.
// Optional ACCUM_SATURATE_EN clamps overflowing beats to the signed max/min instead of wrapping.
module accum_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sum_out,
  output logic             overflow_out,
  output logic [7:0]       count_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(COUNT - 1);
`ifdef ACCUM_SATURATE_EN
  localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] beat_sum;
  logic             add_ovf;
  logic             accept;

  always_comb begin
    add_res = sum_q + in_data;
    // Same-sign addends producing an opposite-sign result.
    add_ovf = (sum_q[WIDTH-1] == in_data[WIDTH-1]) && (add_res[WIDTH-1] != sum_q[WIDTH-1]);
`ifdef ACCUM_SATURATE_EN
    if (add_ovf) begin
      beat_sum = sum_q[WIDTH-1] ? MinVal : MaxVal;
    end else begin
      beat_sum = add_res;
    end
`else
    beat_sum = add_res;
`endif
  end

  assign accept = in_valid && (state_q == StAccum);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StAccum;
          sum_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (accept) begin
          sum_d = beat_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q == StAccum);
  assign busy         = (state_q == StAccum);
  assign done         = (state_q == StDone);
  assign sum_out      = sum_q;
  assign overflow_out = ovf_q;
  assign count_out    = cnt_q;

endmodule
